// File: rtl/modo2_pkg.sv
// Shared constants for the FPGAudio mode-2 (recording) controller:
// state encodings and default timing parameters.
package modo2_pkg;

  localparam int ESTADO_W = 4;

  localparam logic [ESTADO_W-1:0] EST_INICIAL  = 4'd0;
  localparam logic [ESTADO_W-1:0] EST_PREPARA  = 4'd1;
  localparam logic [ESTADO_W-1:0] EST_CONTAGEM = 4'd2;
  localparam logic [ESTADO_W-1:0] EST_ESPERA   = 4'd3;
  localparam logic [ESTADO_W-1:0] EST_REGISTRA = 4'd4;
  localparam logic [ESTADO_W-1:0] EST_MEDE     = 4'd5;
  localparam logic [ESTADO_W-1:0] EST_GRAVA    = 4'd6;
  localparam logic [ESTADO_W-1:0] EST_PROXIMO  = 4'd7;
  localparam logic [ESTADO_W-1:0] EST_FIM      = 4'd8;

  localparam int MAX_NOTAS_PADRAO    = 16;
  localparam int DUR_W_PADRAO        = 4;
  localparam int CONTAGEM_PADRAO     = 4;
  localparam int SILENCIO_MAX_PADRAO = 16;

  // The metronome runs from count-in through the end of each note write.
  function automatic logic metro_ativo(input logic [ESTADO_W-1:0] estado);
    return (estado >= EST_CONTAGEM) && (estado <= EST_PROXIMO);
  endfunction

endpackage

// File: rtl/modo2_gravacao_controle_contador.sv
// Saturating tick counter: synchronous clear, tick-gated increment that
// stops at LIMITE, and a flag that is high while the count sits at LIMITE.
module contador_ticks_sat #(
  parameter int W      = 4,
  parameter int LIMITE = 15
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         tick,
  output logic [W-1:0] valor,
  output logic         no_limite
);

  localparam logic [W-1:0] LIM = W'(LIMITE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor <= '0;
    end else if (zera) begin
      valor <= '0;
    end else if (tick && (valor != LIM)) begin
      valor <= valor + 1'b1;
    end
  end

  assign no_limite = (valor == LIM);

endmodule

// File: rtl/modo2_gravacao_controle.sv
// Mode-2 recording controller: count-in, then captures each held key as one
// note-memory write (address, duration in ticks) until stop, silence or full.
module modo2_gravacao_controle
  import modo2_pkg::*;
#(
  parameter int MAX_NOTAS    = MAX_NOTAS_PADRAO,
  parameter int ADDR_W       = 4,
  parameter int DUR_W        = DUR_W_PADRAO,
  parameter int CONTAGEM     = CONTAGEM_PADRAO,
  parameter int SILENCIO_MAX = SILENCIO_MAX_PADRAO
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              finalizar,
  input  logic              nota_feita,
  input  logic              tick_metro,
  output logic [ADDR_W-1:0] endereco,
  output logic [DUR_W-1:0]  duracao,
  output logic              gravaM,
  output logic              registraR,
  output logic              zeraMetro,
  output logic              contaMetro,
  output logic              metro_120BPM,
  output logic              toca,
  output logic [ADDR_W:0]   tamanho,
  output logic              pronto,
  output logic              cheia,
  output logic [3:0]        db_estado
);

  localparam int CW = $clog2(CONTAGEM + 1);
  localparam int SW = $clog2(SILENCIO_MAX + 1);
  localparam logic [ADDR_W-1:0] END_ULT = ADDR_W'(MAX_NOTAS - 1);
  localparam logic [DUR_W-1:0]  DUR_UM  = DUR_W'(1);

  logic [ESTADO_W-1:0] estado, estado_prox;
  logic                fin_pend;

  logic [CW-1:0]    cont_valor;
  logic [SW-1:0]    sil_valor;
  logic [DUR_W-1:0] dur_valor;
  logic             cont_ultimo, sil_ultimo, dur_cheio;
  logic             soltou;

  assign soltou = !nota_feita || finalizar;

  // Count-in and silence counters stop one short of their limit, so the
  // tick that arrives while parked there is the one that ends the phase.
  contador_ticks_sat #(.W(CW), .LIMITE(CONTAGEM - 1)) u_contagem (
    .clock     (clock),
    .reset     (reset),
    .zera      (estado == EST_PREPARA),
    .tick      (tick_metro && (estado == EST_CONTAGEM)),
    .valor     (cont_valor),
    .no_limite (cont_ultimo)
  );

  contador_ticks_sat #(.W(SW), .LIMITE(SILENCIO_MAX - 1)) u_silencio (
    .clock     (clock),
    .reset     (reset),
    .zera      ((estado == EST_PREPARA) || (estado == EST_PROXIMO)),
    .tick      (tick_metro && (estado == EST_ESPERA) && !finalizar && !nota_feita),
    .valor     (sil_valor),
    .no_limite (sil_ultimo)
  );

  contador_ticks_sat #(.W(DUR_W), .LIMITE((1 << DUR_W) - 1)) u_duracao (
    .clock     (clock),
    .reset     (reset),
    .zera      ((estado == EST_PREPARA) || (estado == EST_REGISTRA)),
    .tick      (tick_metro && (estado == EST_MEDE) && !soltou),
    .valor     (dur_valor),
    .no_limite (dur_cheio)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= EST_INICIAL;
    else       estado <= estado_prox;
  end

  always_comb begin
    estado_prox = estado;
    case (estado)
      EST_INICIAL:  if (iniciar) estado_prox = EST_PREPARA;
      EST_PREPARA:  estado_prox = EST_CONTAGEM;
      EST_CONTAGEM: if (tick_metro && cont_ultimo) estado_prox = EST_ESPERA;
      EST_ESPERA: begin
        if (finalizar)                     estado_prox = EST_FIM;
        else if (nota_feita)               estado_prox = EST_REGISTRA;
        else if (tick_metro && sil_ultimo) estado_prox = EST_FIM;
      end
      EST_REGISTRA: estado_prox = EST_MEDE;
      EST_MEDE:     if (soltou) estado_prox = EST_GRAVA;
      EST_GRAVA:    estado_prox = EST_PROXIMO;
      EST_PROXIMO: begin
        if ((endereco == END_ULT) || fin_pend) estado_prox = EST_FIM;
        else                                   estado_prox = EST_ESPERA;
      end
      EST_FIM:      if (iniciar) estado_prox = EST_PREPARA;
      default:      estado_prox = EST_INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco <= '0;
      tamanho  <= '0;
      duracao  <= '0;
      cheia    <= 1'b0;
      fin_pend <= 1'b0;
    end else begin
      case (estado)
        EST_PREPARA: begin
          endereco <= '0;
          tamanho  <= '0;
          duracao  <= '0;
          cheia    <= 1'b0;
          fin_pend <= 1'b0;
        end
        EST_MEDE: begin
          if (finalizar) fin_pend <= 1'b1;
          // A note released before any tick still occupies one tick.
          if (soltou) duracao <= (dur_cheio || (dur_valor != '0)) ? dur_valor : DUR_UM;
        end
        EST_PROXIMO: begin
          tamanho <= tamanho + 1'b1;
          if (endereco == END_ULT) cheia    <= 1'b1;
          else if (!fin_pend)      endereco <= endereco + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign gravaM       = (estado == EST_GRAVA);
  assign registraR    = (estado == EST_REGISTRA);
  assign zeraMetro    = (estado == EST_PREPARA);
  assign contaMetro   = metro_ativo(estado);
  assign metro_120BPM = metro_ativo(estado);
  assign toca         = (estado == EST_MEDE);
  assign pronto       = (estado == EST_FIM);
  assign db_estado    = estado;

endmodule

// File: tb/tb_modo2_gravacao_controle.sv
// Self-checking bench for the mode-2 recording controller: table of notes,
// randomized notes against a note-level model, and multi-cycle corner cases.
module tb_modo2_gravacao_controle;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0, finalizar = 1'b0, nota_feita = 1'b0, tick_metro = 1'b0;
  logic [3:0] endereco, duracao, db_estado;
  logic [4:0] tamanho;
  logic       gravaM, registraR, zeraMetro, contaMetro, metro_120BPM, toca, pronto, cheia;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    int         hold;
    int         gap;
    logic [3:0] dur;
  } nota_t;
  nota_t tabela[6];

  modo2_gravacao_controle dut (
    .clock        (clock),
    .reset        (reset),
    .iniciar      (iniciar),
    .finalizar    (finalizar),
    .nota_feita   (nota_feita),
    .tick_metro   (tick_metro),
    .endereco     (endereco),
    .duracao      (duracao),
    .gravaM       (gravaM),
    .registraR    (registraR),
    .zeraMetro    (zeraMetro),
    .contaMetro   (contaMetro),
    .metro_120BPM (metro_120BPM),
    .toca         (toca),
    .tamanho      (tamanho),
    .pronto       (pronto),
    .cheia        (cheia),
    .db_estado    (db_estado)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset && gravaM) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: endereco=%0d duracao=%0d, expected no write", endereco, duracao);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({endereco, duracao} !== mon_exp) begin
          bad++;
          $display("FAIL write: endereco=%0d duracao=%0d, expected endereco=%0d duracao=%0d",
                   endereco, duracao, mon_exp[7:4], mon_exp[3:0]);
        end
      end
    end
  end

  // note-level reference: stored duration is the tick count, at least 1, capped at 15
  function automatic logic [3:0] modelo_dur(input int hold);
    if (hold < 1)  return 4'd1;
    if (hold > 15) return 4'd15;
    return 4'(hold);
  endfunction

  task automatic chk(input string nome, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nome, act, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(negedge clock);
  endtask

  task automatic pulse_tick();
    tick_metro = 1'b1;
    step();
    tick_metro = 1'b0;
  endtask

  task automatic start_recording(input bit key_during);
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("prepara_state", db_estado, 1);
    chk("prepara_zeraMetro", zeraMetro, 1);
    step();
    chk("contagem_state", db_estado, 2);
    chk("contagem_contaMetro", contaMetro, 1);
    for (int i = 0; i < 4; i++) begin
      nota_feita = key_during && (i < 3);
      pulse_tick();
      chk("countin_state", db_estado, (i == 3) ? 3 : 2);
      chk("countin_no_registraR", registraR, 0);
      step();
    end
    nota_feita = 1'b0;
  endtask

  task automatic record_note(input int hold, input int gap, input int exp_final);
    for (int g = 0; g < gap; g++) begin
      pulse_tick();
      step();
    end
    nota_feita = 1'b1;
    step();
    chk("registraR", registraR, 1);
    step();
    chk("toca", toca, 1);
    for (int h = 0; h < hold; h++) begin
      pulse_tick();
      step();
    end
    nota_feita = 1'b0;
    step();
    step();
    step();
    chk("after_note_state", db_estado, exp_final);
  endtask

  initial begin
    tabela[0] = '{hold: 3,  gap: 0, dur: 4'd3};
    tabela[1] = '{hold: 0,  gap: 1, dur: 4'd1};
    tabela[2] = '{hold: 20, gap: 0, dur: 4'd15};
    tabela[3] = '{hold: 1,  gap: 3, dur: 4'd1};
    tabela[4] = '{hold: 15, gap: 2, dur: 4'd15};
    tabela[5] = '{hold: 16, gap: 0, dur: 4'd15};

    step();
    step();
    chk("reset_state", db_estado, 0);
    chk("reset_endereco", endereco, 0);
    chk("reset_tamanho", tamanho, 0);
    chk("reset_pronto", pronto, 0);
    chk("reset_contaMetro", contaMetro, 0);
    reset = 1'b0;
    step();
    chk("idle_state", db_estado, 0);

    // count-in with a key held for the first three ticks
    start_recording(1'b1);

    // table-driven notes
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({4'(i), tabela[i].dur});
      record_note(tabela[i].hold, tabela[i].gap, 3);
      chk("table_written", exp_q.size(), 0);
      chk("table_tamanho", tamanho, i + 1);
      chk("table_endereco", endereco, i + 1);
    end

    // randomized notes until memory fills
    for (int n = 6; n < 16; n++) begin
      int hold, gap;
      hold = $urandom_range(0, 18);
      gap  = $urandom_range(0, 6);
      exp_q.push_back({4'(n), modelo_dur(hold)});
      record_note(hold, gap, (n == 15) ? 8 : 3);
    end
    chk("full_written", exp_q.size(), 0);
    chk("full_pronto", pronto, 1);
    chk("full_cheia", cheia, 1);
    chk("full_tamanho", tamanho, 16);
    chk("full_endereco", endereco, 15);
    nota_feita = 1'b1;
    pulse_tick();
    step();
    nota_feita = 1'b0;
    step();
    step();
    step();
    chk("full_stays_fim", db_estado, 8);

    // stop request while a note is held for two ticks
    start_recording(1'b0);
    chk("restart_endereco", endereco, 0);
    chk("restart_cheia", cheia, 0);
    exp_q.push_back({4'd0, 4'd2});
    nota_feita = 1'b1;
    step();
    step();
    pulse_tick();
    step();
    pulse_tick();
    step();
    finalizar = 1'b1;
    step();
    step();
    step();
    chk("stop_state", db_estado, 8);
    chk("stop_written", exp_q.size(), 0);
    chk("stop_tamanho", tamanho, 1);
    chk("stop_cheia", cheia, 0);
    chk("stop_pronto", pronto, 1);
    finalizar  = 1'b0;
    nota_feita = 1'b0;
    step();

    // silence timeout after one note
    start_recording(1'b0);
    exp_q.push_back({4'd0, modelo_dur(2)});
    record_note(2, 0, 3);
    for (int t = 0; t < 15; t++) begin
      pulse_tick();
      step();
    end
    chk("silence_15_state", db_estado, 3);
    pulse_tick();
    chk("silence_16_state", db_estado, 8);
    chk("silence_tamanho", tamanho, 1);
    chk("silence_endereco", endereco, 1);
    chk("silence_written", exp_q.size(), 0);
    step();

    // reset in the middle of a note
    start_recording(1'b0);
    exp_q.push_back({4'd0, 4'd1});
    record_note(1, 0, 3);
    nota_feita = 1'b1;
    step();
    step();
    pulse_tick();
    step();
    chk("midnote_toca", toca, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_state", db_estado, 0);
    chk("rst_async_toca", toca, 0);
    chk("rst_async_endereco", endereco, 0);
    chk("rst_async_tamanho", tamanho, 0);
    chk("rst_async_contaMetro", contaMetro, 0);
    nota_feita = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_idle_state", db_estado, 0);
    start_recording(1'b0);
    exp_q.push_back({4'd0, 4'd1});
    record_note(1, 0, 3);
    chk("post_rst_endereco", endereco, 1);
    chk("post_rst_tamanho", tamanho, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/modo2_gravacao_controle.md
Name: modo2_gravacao_controle

Overview:
Recording-mode (mode 2) controller for FPGAudio. It sequences the piano datapath so the user records a melody into note memory while the metronome runs.
- The datapath latches the note code; this block measures each note's held duration in metronome ticks.
- It owns the write address and the duration value, and pulses the memory write.
- Sits beside the mode-1 game controller; the mode selector enables one of them at a time.

Parameters:
MAX_NOTAS, 16, memory depth in notes (power of two)
ADDR_W, 4, log2(MAX_NOTAS)
DUR_W, 4, duration field width in ticks; saturates at 2^DUR_W-1
CONTAGEM, 4, count-in ticks before recording opens
SILENCIO_MAX, 16, consecutive silent ticks that end recording

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
iniciar  in  1  level; starts/restarts recording from inicial or fim
finalizar  in  1  level; user stop request
nota_feita  in  1  level; any key held (already debounced)
tick_metro  in  1  one-cycle pulse per metronome subdivision
endereco  out  ADDR_W  note memory write address
duracao  out  DUR_W  duration to write with gravaM
gravaM  out  1  memory write strobe
registraR  out  1  datapath latches current note code
zeraMetro  out  1  clear metronome
contaMetro  out  1  enable metronome
metro_120BPM  out  1  selects 120 BPM metronome
toca  out  1  buzzer/LED enable for held key
tamanho  out  ADDR_W+1  number of notes recorded
pronto  out  1  recording finished
cheia  out  1  finished because memory is full
db_estado  out  4  current state, for debug

Behaviour:
- Reset is clock/reset as decided: reset asynchronous, active-high; clock clock. Reset forces inicial; all counters and outputs go to 0. No write occurs during or after reset, and memory is untouched. Reset mid-recording discards the current note.
- Moore FSM with state encoding:
  - inicial=0: wait. iniciar -> prepara.
  - prepara=1: clear endereco, tamanho, cheia, and all counters; zeraMetro=1 -> contagem.
  - contagem=2: count ticks; after the CONTAGEM-th tick -> espera_nota. Key presses here are ignored.
  - espera_nota=3:
    - finalizar -> fim (finalizar has priority over nota_feita).
    - else nota_feita -> registra.
    - else on a tick, silence counter +1; silence reaching SILENCIO_MAX -> fim. The timeout applies even when tamanho=0.
  - registra=4: registraR=1; clear duration counter -> mede_nota.
  - mede_nota=5:
    - toca=1.
    - Tick with nota_feita=1: duration +1, saturating.
    - nota_feita=0 or finalizar -> grava. A finalizar seen here sets the fin_pend flag.
    - A release and a tick in the same cycle: the tick is not counted.
  - grava=6: gravaM=1 for exactly one cycle. Writes duracao = max(dur,1), so a sub-tick note stores 1. endereco is stable -> proximo.
  - proximo=7: tamanho +1.
    - endereco == MAX_NOTAS-1 -> fim with cheia=1. Full has priority over fin_pend.
    - else fin_pend -> fim.
    - else endereco +1, clear silence -> espera_nota.
  - fim=8: pronto=1; tamanho, endereco and cheia hold. iniciar -> prepara.
  - Encodings 9..15 -> inicial.
- contaMetro=metro_120BPM=1 in states 2..7; 0 elsewhere.
- Cycle timing:
  - registraR is asserted the cycle after nota_feita is sampled in espera_nota.
  - gravaM is asserted 1 cycle after release is sampled in mede_nota.
  - Minimum per-note cost is 4 cycles.
- Output timing: all outputs are decoded from the state register. endereco, duracao and tamanho are registers.

Decomposition:
- Package modo2_pkg holds:
  - the state encodings as localparams;
  - default CONTAGEM, SILENCIO_MAX and DUR_W.
- One sub-module, contador_ticks_sat: a width-parameterised counter with zera, tick-gated increment, saturation, and an equal-to-limit flag. It is instantiated three times: count-in, silence, duration.
- The FSM stays in the top module.

Test Plan:
- Count-in: iniciar; 4 ticks -> state goes 2 to 3 only after the 4th tick. Key press during count-in -> no registraR.
- Single note: key held across 3 ticks, then released -> one gravaM pulse with endereco=0, duracao=3. Afterwards tamanho=1, endereco=1.
- Short note and saturation:
  - Press/release with no tick -> duracao=1.
  - Hold for 20 ticks with DUR_W=4 -> duracao=15.
- Full memory: record 16 notes -> 16th write at endereco=15, then pronto=1, cheia=1, tamanho=16; no further gravaM.
- Stop and timeout:
  - finalizar during mede_nota (key held 2 ticks) -> note written with duracao=2, then fim; tamanho=1, cheia=0.
  - Separately, 16 silent ticks -> fim with tamanho unchanged.
- Reset mid-note: assert reset in mede_nota -> all outputs 0 immediately and no gravaM. iniciar afterwards restarts at endereco=0.
